// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch (T0-T2), decode, and register-to-register ALU execution (T3-T6).
// Optional build macro CU_SINGLE_STEP_EN: one instruction per 0->1 edge on run.
module control_sequencer #(
    parameter logic [3:0] WAIT_MAX    = 4'd15,
    parameter logic [4:0] HALT_OPCODE = 5'b11111
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        run,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic [31:0] enable,
    output logic [31:0] busSelect,
    output logic        MD_Read,
    output logic [3:0]  Control_Signals,
    output logic [3:0]  state,
    output logic        done,
    output logic        illegal,
    output logic        mem_timeout
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;
    state_t      w_endState;
    logic [3:0]  r_waitCnt;
    logic [3:0]  w_cntNext;
    logic        r_memTimeout;
    logic        w_timeoutHit;
    logic        w_start;

    logic [4:0]  w_opcode;
    logic [3:0]  w_ra;
    logic [3:0]  w_rb;
    logic [3:0]  w_rc;
    logic        w_isHalt;
    logic        w_isBinary;
    logic        w_isUnary;
    logic        w_isIllegal;
    logic        w_isMulDiv;
    logic [31:0] w_raSel;
    logic [31:0] w_rbSel;
    logic [31:0] w_rcSel;
    logic        w_unused;

    assign w_opcode = ir[31:27];
    assign w_ra     = ir[26:23];
    assign w_rb     = ir[22:19];
    assign w_rc     = ir[18:15];
    assign w_unused = ^ir[14:0];

    // Opcode classes; anything that is neither an ALU op nor HALT is illegal.
    assign w_isHalt    = (w_opcode == HALT_OPCODE);
    assign w_isUnary   = (w_opcode == 5'd6) || (w_opcode == 5'd7);
    assign w_isBinary  = (w_opcode <= 5'd5) || ((w_opcode >= 5'd8) && (w_opcode <= 5'd12));
    assign w_isIllegal = !w_isHalt && !w_isUnary && !w_isBinary;
    assign w_isMulDiv  = (w_opcode == 5'd8) || (w_opcode == 5'd9);

    assign w_raSel = 32'd1 << w_ra;
    assign w_rbSel = 32'd1 << w_rb;
    assign w_rcSel = 32'd1 << w_rc;

    assign w_cntNext   = r_waitCnt + 4'd1;
    assign state       = r_state;
    assign mem_timeout = r_memTimeout;

`ifdef CU_SINGLE_STEP_EN
    logic r_runPrev;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_runPrev <= 1'b0;
        end else begin
            r_runPrev <= run;
        end
    end

    assign w_start    = run && !r_runPrev;
    assign w_endState = S_IDLE;
`else
    assign w_start    = run;
    assign w_endState = run ? S_T0 : S_IDLE;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // The wait counter only runs while T1 is stalled and restarts at every T1 entry.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_waitCnt    <= 4'd0;
            r_memTimeout <= 1'b0;
        end else begin
            if ((r_state == S_T1) && !mem_ready && !w_timeoutHit) begin
                r_waitCnt <= w_cntNext;
            end else begin
                r_waitCnt <= 4'd0;
            end
            if (w_timeoutHit) begin
                r_memTimeout <= 1'b1;
            end
        end
    end

    always_comb begin
        w_stateNext  = r_state;
        w_timeoutHit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_stateNext = S_T0;
                end
            end
            S_T0: w_stateNext = S_T1;
            S_T1: begin
                if (mem_ready) begin
                    w_stateNext = S_T2;
                end else if (w_cntNext == WAIT_MAX) begin
                    w_stateNext  = S_IDLE;
                    w_timeoutHit = 1'b1;
                end
            end
            S_T2: w_stateNext = S_T3;
            S_T3: begin
                if (w_isHalt) begin
                    w_stateNext = S_IDLE;
                end else if (w_isBinary || w_isUnary) begin
                    w_stateNext = S_T4;
                end else begin
                    w_stateNext = w_endState;
                end
            end
            S_T4: w_stateNext = S_T5;
            S_T5: w_stateNext = w_isMulDiv ? S_T6 : w_endState;
            S_T6: w_stateNext = w_endState;
            default: w_stateNext = S_IDLE;
        endcase
    end

    // Moore outputs: only the registered state and the decoded IR fields feed these.
    always_comb begin
        enable          = 32'd0;
        busSelect       = 32'd0;
        MD_Read         = 1'b0;
        Control_Signals = 4'd0;
        done            = 1'b0;
        illegal         = 1'b0;
        case (r_state)
            S_T0: begin
                busSelect[20] = 1'b1;
                enable[25]    = 1'b1;
                enable[28]    = 1'b1;
                enable[24]    = 1'b1;
            end
            S_T1: begin
                busSelect[19] = 1'b1;
                enable[20]    = 1'b1;
                enable[21]    = 1'b1;
                MD_Read       = 1'b1;
            end
            S_T2: begin
                busSelect[21] = 1'b1;
                enable[23]    = 1'b1;
            end
            S_T3: begin
                if (w_isHalt) begin
                    done = 1'b1;
                end else if (w_isBinary) begin
                    busSelect  = w_rbSel;
                    enable[27] = 1'b1;
                end else if (w_isIllegal) begin
                    illegal = 1'b1;
                end
            end
            S_T4: begin
                busSelect       = w_isUnary ? w_rbSel : w_rcSel;
                Control_Signals = w_opcode[3:0];
                enable[24]      = 1'b1;
            end
            S_T5: begin
                busSelect[19] = 1'b1;
                if (w_isMulDiv) begin
                    enable[17] = 1'b1;
                end else begin
                    enable = w_raSel;
                    done   = 1'b1;
                end
            end
            S_T6: begin
                busSelect[18] = 1'b1;
                enable[16]    = 1'b1;
                done          = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
